// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one access per enabled cycle, round-robin or
// port-0 priority with a starvation guard for port 1.
// Grant and memory mux are combinational; read data returns one enabled cycle later.
// Backpressure: a requester holds req until it sees gnt; no gnt while clk_en=0 or rst=1.
//
// Ports:
//   clk, rst, clk_en           clock, synchronous active-high reset, shared clock enable
//   m0_* / m1_*                requester ports (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_raddr/waddr/wdata/we   memory-side controls driven by the winner
//   mem_rdata                  memory read data, valid one enabled cycle after raddr
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [15:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [15:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [15:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [15:0]           m1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [15:0]           mem_rdata
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic       last_grant;   // id of the port granted most recently
  logic [7:0] wait_cnt;     // enabled cycles port 1 has been refused in a row
  logic       rd_pend;      // a read was granted on the previous enabled edge
  logic       rd_tag;       // which port owns that read

  logic       active;
  logic       tie_to_1;
  logic       rd_gnt;

  // Tie-break: round-robin favours whoever did not win last time; fixed mode
  // favours port 0 until port 1 has waited MAX_WAIT enabled cycles.
  always_comb begin
    active   = clk_en & ~rst;
    tie_to_1 = (FIXED_PRIO != 0) ? (wait_cnt >= MAX_WAIT_C) : ~last_grant;
    m1_gnt   = active & m1_req & (~m0_req | tie_to_1);
    m0_gnt   = active & m0_req & ~(m1_req & tie_to_1);
    rd_gnt   = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
  end

  // Memory mux follows the grant, so an idle or disabled cycle drives zeros.
  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (m0_gnt) begin
      mem_raddr = m0_addr;
      mem_waddr = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
    end else if (m1_gnt) begin
      mem_raddr = m1_addr;
      mem_waddr = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;   // makes port 0 win the first tie
      wait_cnt   <= 8'd0;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
    end else if (clk_en) begin
      if (m0_gnt | m1_gnt)
        last_grant <= m1_gnt;

      if (!m1_req || m1_gnt)
        wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;

      rd_pend <= rd_gnt;
      if (rd_gnt)
        rd_tag <= m1_gnt;
    end
  end

  // rvalid is masked during reset so a read granted just before rst never
  // reports data.
  assign m0_rvalid = rd_pend & ~rd_tag & ~rst;
  assign m1_rvalid = rd_pend &  rd_tag & ~rst;

  // Data is shared; only rvalid tells a port the word is its own.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW      = 15;
  localparam int FP_WAIT = 3;
  localparam int MSIZE   = 1 << AW;

  logic clk, rst, clk_en;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [15:0]   m0_wdata, m1_wdata;

  // instance 0: round-robin, instance 1: fixed priority with MAX_WAIT=3
  logic r_m0_gnt, r_m0_rvalid, r_m1_gnt, r_m1_rvalid, r_mem_we;
  logic f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid, f_mem_we;
  logic [15:0] r_m0_rdata, r_m1_rdata, r_mem_wdata, r_mrd;
  logic [15:0] f_m0_rdata, f_m1_rdata, f_mem_wdata, f_mrd;
  logic [AW-1:0] r_raddr, r_waddr, f_raddr, f_waddr;

  dmem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(r_m0_gnt), .m0_rvalid(r_m0_rvalid), .m0_rdata(r_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(r_m1_gnt), .m1_rvalid(r_m1_rvalid), .m1_rdata(r_m1_rdata),
    .mem_raddr(r_raddr), .mem_waddr(r_waddr), .mem_wdata(r_mem_wdata),
    .mem_we(r_mem_we), .mem_rdata(r_mrd));

  dmem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1), .MAX_WAIT(FP_WAIT)) u_fp (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
    .mem_raddr(f_raddr), .mem_waddr(f_waddr), .mem_wdata(f_mem_wdata),
    .mem_we(f_mem_we), .mem_rdata(f_mrd));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'hC3A5;
  endfunction

  // Environment memories, one per instance, clock-enabled like the real one.
  logic [15:0] mem_r [0:MSIZE-1];
  logic [15:0] mem_f [0:MSIZE-1];
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MSIZE; i++) begin
        mem_r[i] <= init_val(i);
        mem_f[i] <= init_val(i);
      end
      mem_ready <= 1'b1;
    end else if (clk_en) begin
      if (r_mem_we) mem_r[r_waddr] <= r_mem_wdata;
      if (f_mem_we) mem_f[f_waddr] <= f_mem_wdata;
      r_mrd <= mem_r[r_raddr];
      f_mrd <= mem_f[f_raddr];
    end
  end

  // Collected outputs, indexed by mode (0 = rr, 1 = fixed)
  logic [1:0] o_g0, o_g1, o_we, o_rv0, o_rv1;
  logic [AW-1:0] o_raddr [2];
  logic [AW-1:0] o_waddr [2];
  logic [15:0]   o_wd [2];
  logic [15:0]   o_rd0 [2];
  logic [15:0]   o_rd1 [2];
  assign o_g0  = {f_m0_gnt, r_m0_gnt};
  assign o_g1  = {f_m1_gnt, r_m1_gnt};
  assign o_we  = {f_mem_we, r_mem_we};
  assign o_rv0 = {f_m0_rvalid, r_m0_rvalid};
  assign o_rv1 = {f_m1_rvalid, r_m1_rvalid};
  assign o_raddr[0] = r_raddr;  assign o_raddr[1] = f_raddr;
  assign o_waddr[0] = r_waddr;  assign o_waddr[1] = f_waddr;
  assign o_wd[0]    = r_mem_wdata; assign o_wd[1] = f_mem_wdata;
  assign o_rd0[0]   = r_m0_rdata;  assign o_rd0[1] = f_m0_rdata;
  assign o_rd1[0]   = r_m1_rdata;  assign o_rd1[1] = f_m1_rdata;

  // ---------------- behavioural reference model ----------------
  int          last_port [2];
  int          waited    [2];
  bit          pend_vld  [2];
  int          pend_port [2];
  logic [15:0] pend_data [2];
  logic [15:0] shadow [2][0:MSIZE-1];

  bit          e_g0 [2], e_g1 [2], e_we [2], e_rv0 [2], e_rv1 [2];
  logic [AW-1:0] e_addr [2];
  logic [15:0]   e_wd [2], e_rd [2];

  int errors = 0;
  int checks = 0;

  // Which port owns this cycle in mode m (-1 = nobody)
  function automatic int winner(input int m);
    int w;
    w = -1;
    if (clk_en && !rst) begin
      if (m0_req && m1_req) begin
        if (m == 0) w = 1 - last_port[m];
        else        w = (waited[m] >= FP_WAIT) ? 1 : 0;
      end else if (m0_req) w = 0;
      else if (m1_req) w = 1;
    end
    return w;
  endfunction

  task automatic model_expect();
    int w;
    for (int m = 0; m < 2; m++) begin
      w = winner(m);
      e_g0[m]   = (w == 0);
      e_g1[m]   = (w == 1);
      e_addr[m] = (w == 0) ? m0_addr  : (w == 1) ? m1_addr  : '0;
      e_wd[m]   = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 16'd0;
      e_we[m]   = (w == 0) ? m0_we    : (w == 1) ? m1_we    : 1'b0;
      e_rv0[m]  = !rst && pend_vld[m] && pend_port[m] == 0;
      e_rv1[m]  = !rst && pend_vld[m] && pend_port[m] == 1;
      e_rd[m]   = pend_data[m];
    end
  endtask

  task automatic model_commit();
    int w;
    bit wr;
    logic [AW-1:0] a;
    logic [15:0] d;
    for (int m = 0; m < 2; m++) begin
      w = winner(m);
      if (rst) begin
        last_port[m] = 1; waited[m] = 0; pend_vld[m] = 0; pend_port[m] = 0;
      end else if (clk_en) begin
        wr = (w == 0) ? m0_we    : (w == 1) ? m1_we    : 1'b0;
        a  = (w == 0) ? m0_addr  : m1_addr;
        d  = (w == 0) ? m0_wdata : m1_wdata;
        if (w >= 0) last_port[m] = w;
        if (m1_req && w != 1) waited[m] = (waited[m] < 255) ? waited[m] + 1 : 255;
        else                  waited[m] = 0;
        pend_vld[m] = (w >= 0) && !wr;
        if (pend_vld[m]) begin
          pend_port[m] = w;
          pend_data[m] = shadow[m][a];
        end
        if (w >= 0 && wr) shadow[m][a] = d;
      end
    end
  endtask

  // Drive inputs just after the falling edge, then let combinational paths settle.
  task automatic set_in(input bit ce, input bit r,
                        input bit q0, input bit w0, input logic [AW-1:0] a0, input logic [15:0] d0,
                        input bit q1, input bit w1, input logic [AW-1:0] a1, input logic [15:0] d1);
    @(negedge clk);
    clk_en = ce; rst = r;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    model_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      set_in(1, 1, 1, 0, 15'h0010, 16'h0, 1, 0, 15'h0020, 16'h0);
      for (int m = 0; m < 2; m++) begin
        checks++; if (o_g0[m] !== 1'b0 || o_g1[m] !== 1'b0) begin errors++; $display("FAIL reset_gnt m=%0d got=%b%b exp=00", m, o_g1[m], o_g0[m]); end
        checks++; if (o_we[m] !== 1'b0) begin errors++; $display("FAIL reset_we m=%0d got=%b exp=0", m, o_we[m]); end
        checks++; if (o_rv0[m] !== 1'b0 || o_rv1[m] !== 1'b0) begin errors++; $display("FAIL reset_rvalid m=%0d got=%b%b exp=00", m, o_rv1[m], o_rv0[m]); end
      end
      tick();
    end
  endtask

  task automatic test_rr_tie();
    bit p;
    set_in(1, 1, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0); tick();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_in(1, 0, 1, 0, 15'h0010, 16'h0, 1, 0, 15'h0020, 16'h0);
      else       set_in(1, 0, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0);
      if (k < 4) begin
        p = (k % 2) == 1;
        checks++; if (r_m0_gnt !== !p || r_m1_gnt !== p) begin errors++; $display("FAIL rr_gnt cyc=%0d got=%b%b exp_port=%0d", k, r_m1_gnt, r_m0_gnt, p); end
        checks++; if (r_raddr !== (p ? 15'h0020 : 15'h0010)) begin errors++; $display("FAIL rr_raddr cyc=%0d got=%h", k, r_raddr); end
      end
      if (k > 0) begin
        p = ((k - 1) % 2) == 1;
        checks++; if (r_m0_rvalid !== !p || r_m1_rvalid !== p) begin errors++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp_port=%0d", k, r_m1_rvalid, r_m0_rvalid, p); end
        checks++; if (r_m0_rdata !== init_val(p ? 32'h20 : 32'h10)) begin errors++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", k, r_m0_rdata, init_val(p ? 32'h20 : 32'h10)); end
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    bit pat [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    set_in(1, 1, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0); tick();
    for (int k = 0; k < 8; k++) begin
      set_in(1, 0, 1, 0, 15'h0030, 16'h0, 1, 0, 15'h0040, 16'h0);
      checks++; if (f_m0_gnt !== !pat[k] || f_m1_gnt !== pat[k]) begin errors++; $display("FAIL fp_gnt cyc=%0d got=%b%b exp_port=%0d", k, f_m1_gnt, f_m0_gnt, pat[k]); end
      tick();
    end
  endtask

  task automatic test_write_read();
    set_in(1, 1, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0); tick();
    set_in(1, 0, 1, 1, 15'h1234, 16'hBEEF, 0, 0, '0, 16'h0);
    checks++; if (r_m0_gnt !== 1'b1 || r_mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt got gnt=%b we=%b exp=1 1", r_m0_gnt, r_mem_we); end
    checks++; if (r_waddr !== 15'h1234 || r_mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got %h/%h exp 1234/beef", r_waddr, r_mem_wdata); end
    tick();
    set_in(1, 0, 0, 0, '0, 16'h0, 1, 0, 15'h1234, 16'h0);
    checks++; if (r_m1_gnt !== 1'b1 || r_mem_we !== 1'b0) begin errors++; $display("FAIL wr_rd_gnt got gnt=%b we=%b exp=1 0", r_m1_gnt, r_mem_we); end
    checks++; if (r_m0_rvalid !== 1'b0 || r_m1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b%b exp=00", r_m1_rvalid, r_m0_rvalid); end
    tick();
    set_in(1, 0, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0);
    checks++; if (r_m1_rvalid !== 1'b1 || r_m0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rd_rvalid got=%b%b exp=10", r_m1_rvalid, r_m0_rvalid); end
    checks++; if (r_m1_rdata !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_data got=%h exp=beef", r_m1_rdata); end
    tick();
  endtask

  task automatic test_clk_en();
    set_in(1, 1, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0); tick();
    set_in(1, 0, 0, 0, '0, 16'h0, 1, 0, 15'h0005, 16'h0);
    checks++; if (r_m1_gnt !== 1'b1) begin errors++; $display("FAIL ce_gnt1 got=%b exp=1", r_m1_gnt); end
    tick();
    set_in(0, 0, 0, 0, '0, 16'h0, 1, 0, 15'h0005, 16'h0);
    checks++; if (r_m1_gnt !== 1'b0 || r_m0_gnt !== 1'b0) begin errors++; $display("FAIL ce_off_gnt got=%b%b exp=00", r_m1_gnt, r_m0_gnt); end
    checks++; if (r_m1_rvalid !== 1'b1 || r_m1_rdata !== init_val(5)) begin errors++; $display("FAIL ce_off_rvalid got=%b/%h exp=1/%h", r_m1_rvalid, r_m1_rdata, init_val(5)); end
    tick();
    set_in(1, 0, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0);
    checks++; if (r_m1_rvalid !== 1'b1 || r_m1_gnt !== 1'b0) begin errors++; $display("FAIL ce_hold_rvalid got rv=%b gnt=%b exp=1 0", r_m1_rvalid, r_m1_gnt); end
    tick();
    set_in(1, 0, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0);
    checks++; if (r_m1_rvalid !== 1'b0) begin errors++; $display("FAIL ce_rvalid_clear got=%b exp=0", r_m1_rvalid); end
    tick();
  endtask

  task automatic test_reset_after_read();
    set_in(1, 1, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0); tick();
    set_in(1, 0, 1, 0, 15'h0010, 16'h0, 0, 0, '0, 16'h0); tick();
    set_in(1, 1, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0);
    checks++; if (r_m0_rvalid !== 1'b0 || r_m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rd_during got=%b%b exp=00", r_m1_rvalid, r_m0_rvalid); end
    tick();
    set_in(1, 0, 0, 0, '0, 16'h0, 0, 0, '0, 16'h0);
    checks++; if (r_m0_rvalid !== 1'b0 || r_m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rd_after got=%b%b exp=00", r_m1_rvalid, r_m0_rvalid); end
    tick();
    set_in(1, 0, 1, 0, 15'h0011, 16'h0, 1, 0, 15'h0012, 16'h0);
    checks++; if (r_m0_gnt !== 1'b1 || r_m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_tie got=%b%b exp=01", r_m1_gnt, r_m0_gnt); end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 3),
             1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom),
             1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom));
      for (int m = 0; m < 2; m++) begin
        checks++; if (o_g0[m] !== e_g0[m] || o_g1[m] !== e_g1[m]) begin errors++; $display("FAIL rnd_gnt cyc=%0d m=%0d got=%b%b exp=%b%b", k, m, o_g1[m], o_g0[m], e_g1[m], e_g0[m]); end
        checks++; if (o_we[m] !== e_we[m]) begin errors++; $display("FAIL rnd_we cyc=%0d m=%0d got=%b exp=%b", k, m, o_we[m], e_we[m]); end
        checks++; if (o_raddr[m] !== e_addr[m] || o_waddr[m] !== e_addr[m]) begin errors++; $display("FAIL rnd_addr cyc=%0d m=%0d got=%h/%h exp=%h", k, m, o_raddr[m], o_waddr[m], e_addr[m]); end
        checks++; if (o_wd[m] !== e_wd[m]) begin errors++; $display("FAIL rnd_wdata cyc=%0d m=%0d got=%h exp=%h", k, m, o_wd[m], e_wd[m]); end
        checks++; if (o_rv0[m] !== e_rv0[m] || o_rv1[m] !== e_rv1[m]) begin errors++; $display("FAIL rnd_rvalid cyc=%0d m=%0d got=%b%b exp=%b%b", k, m, o_rv1[m], o_rv0[m], e_rv1[m], e_rv0[m]); end
        if (e_rv0[m] || e_rv1[m]) begin
          checks++; if (o_rd0[m] !== e_rd[m] || o_rd1[m] !== e_rd[m]) begin errors++; $display("FAIL rnd_rdata cyc=%0d m=%0d got=%h/%h exp=%h", k, m, o_rd0[m], o_rd1[m], e_rd[m]); end
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int m = 0; m < 2; m++) begin
      last_port[m] = 1; waited[m] = 0; pend_vld[m] = 0; pend_port[m] = 0; pend_data[m] = '0;
      for (int i = 0; i < MSIZE; i++) shadow[m][i] = init_val(i);
    end
    test_reset();
    test_rr_tie();
    test_fixed_prio();
    test_write_read();
    test_clk_en();
    test_reset_after_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, word-address width of data memory.
REQ-002 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = port 0 priority with starvation guard.
REQ-003 SHALL have parameter MAX_WAIT, default 8; enabled cycles port 1 may wait in FIXED_PRIO mode before it is forced to win (range 1-255).
REQ-004 One clock, synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous reset, active high.
REQ-005 clk_en  in  1  clock enable shared with the data memory; all state advances only on edges with clk_en=1 (except reset).
REQ-006 m0_req  in  1  port 0 access request; held with its fields stable until granted.
REQ-007 m0_we  in  1  port 0 write (1) / read (0).
REQ-008 m0_addr  in  ADDR_WIDTH  port 0 word address.
REQ-009 m0_wdata  in  16  port 0 write data.
REQ-010 m0_gnt  out  1  port 0 request accepted at this edge.
REQ-011 m0_rvalid  out  1  port 0 read data valid on m0_rdata.
REQ-012 m0_rdata  out  16  port 0 read data.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings for port 1.
REQ-014 mem_raddr  out  ADDR_WIDTH, mem_waddr  out  ADDR_WIDTH, mem_wdata  out  16, mem_we  out  1: drive the memory ports.
REQ-015 mem_rdata  in  16  memory read data, 1 enabled-cycle latency after raddr sampled.

Function
REQ-016 Grant: combinational; at most one of m0_gnt/m1_gnt high; no gnt when clk_en=0 or rst=1; gnt high whenever clk_en=1 and any req is high.
REQ-017 Single requester: that port wins.
REQ-018 Both requesting, FIXED_PRIO=0: winner is the port not granted last (last_grant register, updated on each granted enabled edge).
REQ-019 Both requesting, FIXED_PRIO=1: port 0 wins unless wait_cnt >= MAX_WAIT, then port 1 wins.
REQ-020 wait_cnt (8-bit): on enabled edge, +1 if m1_req high and not granted (saturate at 255); cleared when port 1 granted or m1_req low.
REQ-021 Mux: mem_raddr, mem_waddr = winner addr; mem_wdata = winner wdata; mem_we = gnt & winner we; with no winner, addresses/data = 0, mem_we = 0.
REQ-022 Read response: on an enabled edge granting a read, rd_tag <= winner id, rd_pend <= 1; on enabled edge with no read granted, rd_pend <= 0.
REQ-023 mX_rvalid = rd_pend & (rd_tag == X); held until next enabled edge; consumers sample it on a clk_en=1 cycle.
REQ-024 m0_rdata = m1_rdata = mem_rdata (unqualified passthrough); only rvalid identifies the owner.
REQ-025 Back-to-back reads by alternating ports SHALL yield rvalid on alternating ports each enabled cycle without bubbles.
REQ-026 A granted write SHALL NOT assert any rvalid; write followed by read of the same address returns the new data.
REQ-027 clk_en=0 cycles: no grants, last_grant, wait_cnt, rd_pend, rd_tag hold.
REQ-028 Requester dropping req before gnt is legal; no state change results.

Reset
REQ-029 rst=1 at a clock edge (regardless of clk_en): rd_pend=0, rd_tag=0, last_grant=1 (port 0 wins first tie), wait_cnt=0.
REQ-030 During rst: m0_gnt=m1_gnt=0, mem_we=0, m0_rvalid=m1_rvalid=0; a read granted before rst yields no rvalid after it.

Verification
REQ-031 Reset, clk_en=1, both read (addr 0x0010, 0x0020) held 4 cycles, FIXED_PRIO=0 -> gnt order 0,1,0,1; rvalid order 0,1,0,1 one cycle later with matching data.
REQ-032 FIXED_PRIO=1, MAX_WAIT=3, both req continuously -> gnt 0,0,0,1,0,0,0,1; wait_cnt clears at each port-1 grant.
REQ-033 Port 0 write 0xBEEF to 0x1234, then port 1 read 0x1234 -> m1_rvalid one enabled cycle later with m1_rdata=0xBEEF; m0_rvalid stays 0.
REQ-034 clk_en toggling 1,0,1 with port 1 read of 0x0005 -> single gnt on first enabled cycle; m1_rvalid held through clk_en=0 cycle; no duplicate grant.
REQ-035 rst asserted the cycle after a granted read -> no rvalid on either port; next tie goes to port 0.
